// File: rtl/biquad_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : biquad_channel_scheduler
// Description : Time-multiplexes one stateless biquad MAC engine between
//               N_CH audio channels. Keeps per-channel filter history
//               (x1, x2, y1, y2) and double-buffered Q2.14 coefficients.
//               Pending samples are arbitrated round-robin. Each grant
//               issues one engine job. Each result is returned tagged with
//               its channel.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_in_valid[N_CH]        per-channel new-sample pulse
//   i_in_sample[16*N_CH]    signed samples, channel c at [16c+15:16c]
//   i_cfg_we/ch/idx/data    shadow coefficient write (0=b0 1=b1 2=b2 3=a1 4=a2)
//   i_cfg_commit            request shadow->active copy at next IDLE
//   o_eng_trigger           1-cycle engine job start
//   o_eng_x0..o_eng_a2      registered operands for the granted channel
//   i_eng_result/ready      engine result and its 1-cycle valid pulse
//   o_out_valid/ch/sample   filtered sample out, tagged with its channel
//   o_overrun[N_CH]         sticky: sample lost to an overwrite
//   o_timeout_err           sticky: a job was aborted waiting for the engine
//   o_busy                  FSM not in IDLE
// ============================================================================
module biquad_channel_scheduler #(
  parameter int N_CH    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      i_in_valid,
  input  logic [16*N_CH-1:0]   i_in_sample,
  input  logic                 i_cfg_we,
  input  logic [2:0]           i_cfg_ch,
  input  logic [2:0]           i_cfg_idx,
  input  logic [15:0]          i_cfg_data,
  input  logic                 i_cfg_commit,
  output logic                 o_eng_trigger,
  output logic [15:0]          o_eng_x0,
  output logic [15:0]          o_eng_x1,
  output logic [15:0]          o_eng_x2,
  output logic [15:0]          o_eng_y1,
  output logic [15:0]          o_eng_y2,
  output logic [15:0]          o_eng_b0,
  output logic [15:0]          o_eng_b1,
  output logic [15:0]          o_eng_b2,
  output logic [15:0]          o_eng_a1,
  output logic [15:0]          o_eng_a2,
  input  logic [15:0]          i_eng_result,
  input  logic                 i_eng_ready,
  output logic                 o_out_valid,
  output logic [2:0]           o_out_ch,
  output logic [15:0]          o_out_sample,
  output logic [N_CH-1:0]      o_overrun,
  output logic                 o_timeout_err,
  output logic                 o_busy
);

  localparam int c_IW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_CW    = $clog2(TIMEOUT + 1);
  localparam int c_NCOEF = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  // Pending sample buffers
  logic [N_CH-1:0]   r_pend;
  logic [15:0]       r_pend_data [N_CH];
  logic [N_CH-1:0]   r_overrun;

  // Per-channel filter history
  logic [15:0]       r_x1 [N_CH];
  logic [15:0]       r_x2 [N_CH];
  logic [15:0]       r_y1 [N_CH];
  logic [15:0]       r_y2 [N_CH];

  // Coefficient banks
  logic [15:0]       r_shd [N_CH][c_NCOEF];
  logic [15:0]       r_act [N_CH][c_NCOEF];
  logic              r_commit_req;

  // Arbitration and job bookkeeping
  logic [c_IW-1:0]   r_rr;
  logic [c_IW-1:0]   r_gch;
  logic [c_IW-1:0]   w_gsel;
  logic              w_any;
  logic [N_CH-1:0]   w_gclr;
  logic [c_CW-1:0]   r_wcnt;
  logic [15:0]       r_result;
  logic              r_timeout_err;

  // Registered engine operands
  logic [15:0]       r_op_x0, r_op_x1, r_op_x2, r_op_y1, r_op_y2;
  logic [15:0]       r_op_b0, r_op_b1, r_op_b2, r_op_a1, r_op_a2;

  // FSM control strobes
  logic              w_copy;
  logic              w_grant;
  logic              w_capture;
  logic              w_abort;
  logic              w_hist_we;

  // --------------------------------------------------------------------------
  // Round-robin search: first pending channel starting at rr+1 (mod N_CH).
  // Iterating from the farthest offset down lets the nearest one win.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any  = 1'b0;
    w_gsel = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (r_pend[(int'(r_rr) + k) % N_CH]) begin
        w_any  = 1'b1;
        w_gsel = c_IW'((int'(r_rr) + k) % N_CH);
      end
    end
  end

  always_comb begin
    w_gclr = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_gclr[c] = w_grant && (w_gsel == c_IW'(c));
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_copy        = 1'b0;
    w_grant       = 1'b0;
    w_capture     = 1'b0;
    w_abort       = 1'b0;
    w_hist_we     = 1'b0;
    o_eng_trigger = 1'b0;
    o_out_valid   = 1'b0;
    o_busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        // A pending commit takes the whole IDLE cycle; arbitration waits.
        if (r_commit_req) begin
          w_copy = 1'b1;
        end else if (w_any) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_eng_trigger = 1'b1;
        w_next        = S_WAIT;
      end
      S_WAIT: begin
        if (i_eng_ready) begin
          w_capture = 1'b1;
          w_next    = S_COMMIT;
        end else if (r_wcnt == c_CW'(TIMEOUT - 1)) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_COMMIT: begin
        o_out_valid = 1'b1;
        w_hist_we   = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending buffers. A new sample always wins over a same-cycle grant clear.
  // Overrun flags only a sample that is actually lost: if the old one is
  // being granted this cycle it has been consumed, not overwritten.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_overrun <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_pend_data[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_in_valid[c]) begin
          r_pend[c]      <= 1'b1;
          r_pend_data[c] <= i_in_sample[16*c +: 16];
          if (r_pend[c] && !w_gclr[c]) begin
            r_overrun[c] <= 1'b1;
          end
        end else if (w_gclr[c]) begin
          r_pend[c] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient banks. Shadow writes are accepted any cycle; the copy to the
  // active bank only happens in IDLE, so a running job never sees a change.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_req <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < c_NCOEF; k++) begin
          r_shd[c][k] <= '0;
          r_act[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < c_NCOEF; k++) begin
          if (i_cfg_we && (int'(i_cfg_ch) == c) && (int'(i_cfg_idx) == k)) begin
            r_shd[c][k] <= i_cfg_data;
          end
          if (w_copy) begin
            r_act[c][k] <= r_shd[c][k];
          end
        end
      end
      // A commit arriving during the copy cycle keeps the request alive so
      // any shadow write made alongside it is not lost.
      r_commit_req <= i_cfg_commit | (r_commit_req & ~w_copy);
    end
  end

  // --------------------------------------------------------------------------
  // Grant, operand capture, wait counter, result and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr          <= c_IW'(N_CH - 1);
      r_gch         <= '0;
      r_wcnt        <= '0;
      r_result      <= '0;
      r_timeout_err <= 1'b0;
      r_op_x0       <= '0;
      r_op_x1       <= '0;
      r_op_x2       <= '0;
      r_op_y1       <= '0;
      r_op_y2       <= '0;
      r_op_b0       <= '0;
      r_op_b1       <= '0;
      r_op_b2       <= '0;
      r_op_a1       <= '0;
      r_op_a2       <= '0;
    end else begin
      if (w_grant) begin
        r_rr    <= w_gsel;
        r_gch   <= w_gsel;
        r_op_x0 <= r_pend_data[w_gsel];
        r_op_x1 <= r_x1[w_gsel];
        r_op_x2 <= r_x2[w_gsel];
        r_op_y1 <= r_y1[w_gsel];
        r_op_y2 <= r_y2[w_gsel];
        r_op_b0 <= r_act[w_gsel][0];
        r_op_b1 <= r_act[w_gsel][1];
        r_op_b2 <= r_act[w_gsel][2];
        r_op_a1 <= r_act[w_gsel][3];
        r_op_a2 <= r_act[w_gsel][4];
      end
      if (r_state == S_ISSUE) begin
        r_wcnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + c_CW'(1);
      end
      if (w_capture) begin
        r_result <= i_eng_result;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // History update for the granted channel. An aborted job never reaches
  // COMMIT, so its channel history stays as it was.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_x1[c] <= '0;
        r_x2[c] <= '0;
        r_y1[c] <= '0;
        r_y2[c] <= '0;
      end
    end else if (w_hist_we) begin
      r_x2[r_gch] <= r_x1[r_gch];
      r_x1[r_gch] <= r_op_x0;
      r_y2[r_gch] <= r_y1[r_gch];
      r_y1[r_gch] <= r_result;
    end
  end

  assign o_eng_x0      = r_op_x0;
  assign o_eng_x1      = r_op_x1;
  assign o_eng_x2      = r_op_x2;
  assign o_eng_y1      = r_op_y1;
  assign o_eng_y2      = r_op_y2;
  assign o_eng_b0      = r_op_b0;
  assign o_eng_b1      = r_op_b1;
  assign o_eng_b2      = r_op_b2;
  assign o_eng_a1      = r_op_a1;
  assign o_eng_a2      = r_op_a2;
  assign o_out_ch      = 3'(r_gch);
  assign o_out_sample  = r_result;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_biquad_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_biquad_channel_scheduler
// Description : Directed self-checking bench for biquad_channel_scheduler
//               (N_CH=2, TIMEOUT=31). The engine is played by the bench.
// Revision    : 1.0  initial release
// ============================================================================
module tb_biquad_channel_scheduler;

  localparam int c_N_CH    = 2;
  localparam int c_TIMEOUT = 31;

  logic        clk;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [31:0] in_sample;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_data;
  logic        cfg_commit;
  logic        eng_trigger;
  logic [15:0] eng_x0, eng_x1, eng_x2, eng_y1, eng_y2;
  logic [15:0] eng_b0, eng_b1, eng_b2, eng_a1, eng_a2;
  logic [15:0] eng_result;
  logic        eng_ready;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic [15:0] out_sample;
  logic [1:0]  overrun;
  logic        timeout_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  biquad_channel_scheduler #(
    .N_CH    (c_N_CH),
    .TIMEOUT (c_TIMEOUT)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_in_valid    (in_valid),
    .i_in_sample   (in_sample),
    .i_cfg_we      (cfg_we),
    .i_cfg_ch      (cfg_ch),
    .i_cfg_idx     (cfg_idx),
    .i_cfg_data    (cfg_data),
    .i_cfg_commit  (cfg_commit),
    .o_eng_trigger (eng_trigger),
    .o_eng_x0      (eng_x0),
    .o_eng_x1      (eng_x1),
    .o_eng_x2      (eng_x2),
    .o_eng_y1      (eng_y1),
    .o_eng_y2      (eng_y2),
    .o_eng_b0      (eng_b0),
    .o_eng_b1      (eng_b1),
    .o_eng_b2      (eng_b2),
    .o_eng_a1      (eng_a1),
    .o_eng_a2      (eng_a2),
    .i_eng_result  (eng_result),
    .i_eng_ready   (eng_ready),
    .o_out_valid   (out_valid),
    .o_out_ch      (out_ch),
    .o_out_sample  (out_sample),
    .o_overrun     (overrun),
    .o_timeout_err (timeout_err),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] v, input logic [15:0] s0, input logic [15:0] s1);
    in_valid  = v;
    in_sample = {s1, s0};
    tick();
    in_valid  = 2'b00;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [2:0] idx, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_idx  = idx;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Bounded wait for the job start; leaves the bench in the ISSUE cycle.
  task automatic wait_trig(input string tag);
    int n = 0;
    while (!eng_trigger && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_trig"}, 32'(eng_trigger), 32'd1);
  endtask

  // Called from a WAIT cycle: answer the engine job and check the output.
  task automatic finish_job(input string tag, input logic [15:0] res, input logic [2:0] ch);
    eng_ready  = 1'b1;
    eng_result = res;
    tick();
    eng_ready  = 1'b0;
    chk({tag, "_ov"},  32'(out_valid),  32'd1);
    chk({tag, "_och"}, 32'(out_ch),     32'(ch));
    chk({tag, "_out"}, 32'(out_sample), 32'(res));
    tick();
    chk({tag, "_ov_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int nov;
    rst_n      = 1'b0;
    in_valid   = '0;
    in_sample  = '0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_idx    = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    eng_result = '0;
    eng_ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_trig",  32'(eng_trigger), 32'd0);
    chk("rst_ov",    32'(out_valid),   32'd0);
    chk("rst_overr", 32'(overrun),     32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    chk("rst_x0",    32'(eng_x0),      32'd0);
    chk("rst_out",   32'(out_sample),  32'd0);
    rst_n = 1'b1;
    tick();

    // Round-robin from reset pointer: ch0 first, then ch1
    send(2'b11, 16'h0100, 16'h0200);
    wait_trig("rr0");
    chk("rr0_x0", 32'(eng_x0), 32'h0100);
    chk("rr0_x1", 32'(eng_x1), 32'h0000);
    tick();
    finish_job("rr0", 16'h0111, 3'd0);
    wait_trig("rr1");
    chk("rr1_x0", 32'(eng_x0), 32'h0200);
    tick();
    finish_job("rr1", 16'h0222, 3'd1);
    send(2'b10, 16'h0000, 16'h0300);
    wait_trig("rr2");
    chk("rr2_x0", 32'(eng_x0), 32'h0300);
    chk("rr2_x1", 32'(eng_x1), 32'h0200);
    chk("rr2_x2", 32'(eng_x2), 32'h0000);
    chk("rr2_y1", 32'(eng_y1), 32'h0222);
    tick();
    finish_job("rr2", 16'h0333, 3'd1);

    // Single channel with exact latency; eng_ready during ISSUE is ignored
    cfg_write(3'd0, 3'd0, 16'h4000);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    send(2'b01, 16'h1234, 16'h0000);
    chk("lat_t1", 32'(eng_trigger), 32'd0);
    tick();
    chk("lat_t2", 32'(eng_trigger), 32'd1);
    chk("s1_x0",  32'(eng_x0), 32'h1234);
    chk("s1_x1",  32'(eng_x1), 32'h0100);
    chk("s1_y1",  32'(eng_y1), 32'h0111);
    chk("s1_b0",  32'(eng_b0), 32'h4000);
    chk("s1_b1",  32'(eng_b1), 32'h0000);
    eng_ready  = 1'b1;
    eng_result = 16'hDEAD;
    tick();
    eng_ready  = 1'b0;
    chk("issue_ign_ov",   32'(out_valid), 32'd0);
    chk("issue_ign_busy", 32'(busy),      32'd1);
    finish_job("s1", 16'h1234, 3'd0);

    // History: ch0 samples 1,2,3
    for (int i = 1; i <= 3; i++) begin
      send(2'b01, 16'(i), 16'h0000);
      wait_trig("hist");
      if (i == 3) begin
        chk("hist_x0", 32'(eng_x0), 32'd3);
        chk("hist_x1", 32'(eng_x1), 32'd2);
        chk("hist_x2", 32'(eng_x2), 32'd1);
        chk("hist_y1", 32'(eng_y1), 32'h0022);
        chk("hist_y2", 32'(eng_y2), 32'h0011);
      end
      tick();
      finish_job("hist", 16'(i * 16'h0011), 3'd0);
    end

    // Overrun: two ch1 samples while ch0 is in the engine
    send(2'b01, 16'h0500, 16'h0000);
    wait_trig("ovr0");
    tick();
    in_valid  = 2'b10;
    in_sample = {16'h0600, 16'h0000};
    tick();
    in_sample = {16'h0700, 16'h0000};
    tick();
    in_valid  = 2'b00;
    chk("ovr_flag", 32'(overrun), 32'h2);
    finish_job("ovr0", 16'h0555, 3'd0);
    wait_trig("ovr1");
    chk("ovr1_x0", 32'(eng_x0), 32'h0700);
    chk("ovr1_x1", 32'(eng_x1), 32'h0300);
    chk("ovr1_x2", 32'(eng_x2), 32'h0200);
    chk("ovr1_y1", 32'(eng_y1), 32'h0333);
    tick();
    finish_job("ovr1", 16'h0777, 3'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (eng_trigger) n++;
    end
    chk("ovr_once", 32'(n), 32'd0);

    // Timeout: engine never answers
    send(2'b01, 16'h0A00, 16'h0000);
    wait_trig("to");
    chk("to_x0", 32'(eng_x0), 32'h0A00);
    n   = 0;
    nov = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      if (out_valid) nov++;
      if (n == c_TIMEOUT) chk("to_early", 32'(timeout_err), 32'd0);
    end
    chk("to_cycles", 32'(n),           32'(c_TIMEOUT + 1));
    chk("to_flag",   32'(timeout_err), 32'd1);
    chk("to_no_ov",  32'(nov),         32'd0);
    send(2'b01, 16'h0B00, 16'h0000);
    wait_trig("after_to");
    chk("ato_x0", 32'(eng_x0), 32'h0B00);
    chk("ato_x1", 32'(eng_x1), 32'h0500);
    chk("ato_x2", 32'(eng_x2), 32'h0003);
    chk("ato_y1", 32'(eng_y1), 32'h0555);
    chk("ato_y2", 32'(eng_y2), 32'h0033);
    tick();
    finish_job("ato", 16'h0BBB, 3'd0);

    // Commit during WAIT: current job keeps old coefs, next job gets new
    cfg_write(3'd0, 3'd1, 16'h1111);
    send(2'b01, 16'h0C00, 16'h0000);
    wait_trig("cm0");
    chk("cm0_b1", 32'(eng_b1), 32'h0000);
    chk("cm0_b0", 32'(eng_b0), 32'h4000);
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("cm0_hold_b1", 32'(eng_b1), 32'h0000);
    finish_job("cm0", 16'h0CCC, 3'd0);
    send(2'b01, 16'h0E00, 16'h0000);
    wait_trig("cm1");
    chk("cm1_b1", 32'(eng_b1), 32'h1111);
    chk("cm1_b0", 32'(eng_b0), 32'h4000);
    chk("cm1_x1", 32'(eng_x1), 32'h0C00);
    tick();
    finish_job("cm1", 16'h0EEE, 3'd0);

    // Reset during WAIT
    send(2'b10, 16'h0000, 16'h0F00);
    wait_trig("rw");
    chk("rw_x0", 32'(eng_x0), 32'h0F00);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_busy",  32'(busy),        32'd0);
    chk("rw_trig",  32'(eng_trigger), 32'd0);
    chk("rw_ov",    32'(out_valid),   32'd0);
    chk("rw_x0z",   32'(eng_x0),      32'd0);
    chk("rw_b0z",   32'(eng_b0),      32'd0);
    chk("rw_overr", 32'(overrun),     32'd0);
    chk("rw_terr",  32'(timeout_err), 32'd0);
    eng_ready  = 1'b1;
    eng_result = 16'h1234;
    tick();
    eng_ready  = 1'b0;
    rst_n      = 1'b1;
    nov = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) nov++;
    end
    chk("rw_no_ov", 32'(nov),  32'd0);
    chk("rw_idle",  32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
